// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
// Shared AHB-lite definitions for the memory-backed slave:
//   - htrans_t    : transfer type encoding (IDLE, BUSY, NONSEQ, SEQ)
//   - HSIZE_*     : supported transfer sizes (byte, halfword, word)
//   - HRESP_*     : single-bit response encoding
//   - slv_state_t : response FSM states (OKAY, ERR1, ERR2)
//   - AHB_*_WIDTH : default bus widths
//   - lane_enable / size_align_bad : address-phase decode helpers
// ---------------------------------------------------------------------------
package ahb_pkg;

   localparam int AHB_ADDR_WIDTH = 32;
   localparam int AHB_DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'd0,
      HTRANS_BUSY   = 2'd1,
      HTRANS_NONSEQ = 2'd2,
      HTRANS_SEQ    = 2'd3
   } htrans_t;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      ST_OKAY = 2'd0,
      ST_ERR1 = 2'd1,
      ST_ERR2 = 2'd2
   } slv_state_t;

   // Byte-lane write enables for a little-endian 32-bit bus.
   function automatic logic [3:0] lane_enable(input logic [2:0] size, input logic [1:0] lo);
      logic [3:0] be;
      case (size)
         HSIZE_BYTE: be = 4'b0001 << lo;
         HSIZE_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
         HSIZE_WORD: be = 4'b1111;
         default:    be = 4'b0000;
      endcase
      return be;
   endfunction

   // Illegal size or a transfer not aligned to its own size.
   function automatic logic size_align_bad(input logic [2:0] size, input logic [1:0] lo);
      logic bad;
      case (size)
         HSIZE_BYTE: bad = 1'b0;
         HSIZE_HALF: bad = lo[0];
         HSIZE_WORD: bad = (lo != 2'b00);
         default:    bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/ahb_slave_mem.sv
// ---------------------------------------------------------------------------
// ahb_slave_mem
// DEPTH x DATA_WIDTH word memory with per-byte write enables, synchronous
// clear of every word and an asynchronous read port.
// Ports:
//   hclk  : clock
//   clr   : synchronous clear of all words (has priority over writes)
//   we    : byte-lane write enables
//   waddr : word index for writes
//   wdata : write data, lane-aligned
//   raddr : word index for reads
//   rdata : read data (combinational)
// ---------------------------------------------------------------------------
module ahb_slave_mem
   import ahb_pkg::*;
#(
   parameter int DEPTH      = 256,
   parameter int IDX_W      = 8,
   parameter int DATA_WIDTH = AHB_DATA_WIDTH
) (
   input  logic                  hclk,
   input  logic                  clr,
   input  logic [3:0]            we,
   input  logic [IDX_W-1:0]      waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [IDX_W-1:0]      raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];

   // Storage array: clear-all or byte-masked write.
   always_ff @(posedge hclk) begin
      if (clr) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {DATA_WIDTH{1'b0}};
         end
      end else begin
         for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
               mem_r[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

   // Asynchronous read port.
   always_comb begin
      rdata = mem_r[raddr];
   end

endmodule

// File: rtl/ahb_lite_slave.sv
// ---------------------------------------------------------------------------
// ahb_lite_slave
// AHB-lite memory-backed slave. OKAY transfers complete with zero wait
// states; an illegal transfer gets the two-cycle ERROR response
// (ERR1: hreadyout=0/hresp=1, ERR2: hreadyout=1/hresp=1).
// Ports:
//   hclk, hreset          : clock and synchronous active-high reset
//   hsel, haddr, htrans,
//   hwrite, hsize         : address-phase controls
//   hburst, hprot         : accepted but unused
//   hready                : combined bus ready from the interconnect
//   hwdata                : write data (data phase)
//   hrdata                : read data (data phase, combinational)
//   hreadyout, hresp      : slave ready and response
// ---------------------------------------------------------------------------
module ahb_lite_slave
   import ahb_pkg::*;
#(
   parameter int ADDR_WIDTH = AHB_ADDR_WIDTH,
   parameter int DATA_WIDTH = AHB_DATA_WIDTH,
   parameter int MEM_DEPTH  = 256
) (
   input  logic                  hclk,
   input  logic                  hreset,
   input  logic                  hsel,
   input  logic [ADDR_WIDTH-1:0] haddr,
   input  logic [1:0]            htrans,
   input  logic                  hwrite,
   input  logic [2:0]            hsize,
   input  logic [2:0]            hburst,
   input  logic [3:0]            hprot,
   input  logic                  hready,
   input  logic [DATA_WIDTH-1:0] hwdata,
   output logic [DATA_WIDTH-1:0] hrdata,
   output logic                  hreadyout,
   output logic                  hresp
);

   localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [ADDR_WIDTH-3:0] DEPTH_WORDS = (ADDR_WIDTH-2)'(MEM_DEPTH);

   slv_state_t            state_r;
   slv_state_t            state_nxt_s;
   htrans_t               trans_s;
   logic                  accept_s;
   logic                  err_s;
   logic                  sample_s;
   logic                  dvalid_r;
   logic                  write_r;
   logic [2:0]            size_r;
   logic [IDX_W+1:0]      addr_r;
   logic [3:0]            we_s;
   logic [DATA_WIDTH-1:0] mem_rdata_s;
   logic                  unused_s;

   assign unused_s = ^{hburst, hprot};
   assign trans_s  = htrans_t'(htrans);

   // Address-phase decode: transfer request and error classification.
   always_comb begin
      accept_s = 1'b0;
      err_s    = 1'b0;
      if (hsel && ((trans_s == HTRANS_NONSEQ) || (trans_s == HTRANS_SEQ))) begin
         accept_s = 1'b1;
      end else begin
         accept_s = 1'b0;
      end
      if (haddr[ADDR_WIDTH-1:2] >= DEPTH_WORDS) begin
         err_s = 1'b1;
      end else if (size_align_bad(hsize, haddr[1:0])) begin
         err_s = 1'b1;
      end else begin
         err_s = 1'b0;
      end
   end

   // The bus is never sampled in ERR1: hready is low there for a compliant
   // interconnect, and this guards against one that is not.
   always_comb begin
      sample_s = 1'b0;
      if (hready && (state_r != ST_ERR1)) begin
         sample_s = 1'b1;
      end else begin
         sample_s = 1'b0;
      end
   end

   // Response FSM next-state logic.
   always_comb begin
      state_nxt_s = ST_OKAY;
      case (state_r)
         ST_OKAY: begin
            if (sample_s && accept_s && err_s) begin
               state_nxt_s = ST_ERR1;
            end else begin
               state_nxt_s = ST_OKAY;
            end
         end
         ST_ERR1: begin
            state_nxt_s = ST_ERR2;
         end
         ST_ERR2: begin
            if (!sample_s) begin
               state_nxt_s = ST_ERR2;
            end else if (accept_s && err_s) begin
               state_nxt_s = ST_ERR1;
            end else begin
               state_nxt_s = ST_OKAY;
            end
         end
         default: begin
            state_nxt_s = ST_OKAY;
         end
      endcase
   end

   // Response FSM state register.
   always_ff @(posedge hclk) begin
      if (hreset) begin
         state_r <= ST_OKAY;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Address-phase register; dvalid_r marks an OKAY data phase only, so an
   // erroring transfer never reaches the memory or hrdata.
   always_ff @(posedge hclk) begin
      if (hreset) begin
         dvalid_r <= 1'b0;
         write_r  <= 1'b0;
         size_r   <= 3'd0;
         addr_r   <= {(IDX_W+2){1'b0}};
      end else if (sample_s) begin
         dvalid_r <= accept_s & ~err_s;
         write_r  <= hwrite;
         size_r   <= hsize;
         addr_r   <= haddr[IDX_W+1:0];
      end
   end

   // Write commits at the edge that ends the data phase.
   always_comb begin
      we_s = 4'b0000;
      if (dvalid_r && write_r && hready) begin
         we_s = lane_enable(size_r, addr_r[1:0]);
      end else begin
         we_s = 4'b0000;
      end
   end

   ahb_slave_mem #(
      .DEPTH      (MEM_DEPTH),
      .IDX_W      (IDX_W),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_mem (
      .hclk  (hclk),
      .clr   (hreset),
      .we    (we_s),
      .waddr (addr_r[IDX_W+1:2]),
      .wdata (hwdata),
      .raddr (addr_r[IDX_W+1:2]),
      .rdata (mem_rdata_s)
   );

   // Output decode from the registered state and data-phase flags.
   always_comb begin
      hreadyout = 1'b1;
      hresp     = HRESP_OKAY;
      hrdata    = {DATA_WIDTH{1'b0}};
      case (state_r)
         ST_OKAY: begin
            hreadyout = 1'b1;
            hresp     = HRESP_OKAY;
         end
         ST_ERR1: begin
            hreadyout = 1'b0;
            hresp     = HRESP_ERROR;
         end
         ST_ERR2: begin
            hreadyout = 1'b1;
            hresp     = HRESP_ERROR;
         end
         default: begin
            hreadyout = 1'b1;
            hresp     = HRESP_OKAY;
         end
      endcase
      if (dvalid_r && !write_r) begin
         hrdata = mem_rdata_s;
      end else begin
         hrdata = {DATA_WIDTH{1'b0}};
      end
   end

endmodule

// File: tb/tb_ahb_lite_slave.sv
// ---------------------------------------------------------------------------
// tb_ahb_lite_slave
// Scoreboard bench: each issued cycle pushes the expected response for the
// cycle(s) it produces; a negedge monitor pops and compares. Expected data
// comes from a byte-addressed reference memory.
// ---------------------------------------------------------------------------
module tb_ahb_lite_slave;

   logic        hclk = 1'b0;
   logic        hreset;
   logic        hsel;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [2:0]  hburst;
   logic [3:0]  hprot;
   logic        hready;
   logic [31:0] hwdata;
   logic [31:0] hrdata;
   logic        hreadyout;
   logic        hresp;

   assign hready = hreadyout;

   always #5 hclk = ~hclk;

   ahb_lite_slave #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .MEM_DEPTH  (256)
   ) dut (
      .hclk      (hclk),
      .hreset    (hreset),
      .hsel      (hsel),
      .haddr     (haddr),
      .htrans    (htrans),
      .hwrite    (hwrite),
      .hsize     (hsize),
      .hburst    (hburst),
      .hprot     (hprot),
      .hready    (hready),
      .hwdata    (hwdata),
      .hrdata    (hrdata),
      .hreadyout (hreadyout),
      .hresp     (hresp)
   );

   typedef struct {
      logic [31:0] rd;
      logic        rdy;
      logic        resp;
      int          due;
      int          tag;
   } exp_t;

   exp_t        q[$];
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          tag_n = 0;
   logic        done = 1'b0;
   logic        fin = 1'b0;
   logic [7:0]  mem_b [0:1023];
   logic [31:0] pend_wdata = 32'd0;

   always @(posedge hclk) cyc <= cyc + 1;

   // ---------------- reference model ----------------
   function automatic logic model_err(input logic [31:0] a, input logic [2:0] s);
      if (a >= 32'd1024) return 1'b1;
      if (s > 3'd2) return 1'b1;
      if ((a % (32'd1 << s)) != 32'd0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [2:0] s, input logic [31:0] wd);
      logic [31:0] sh;
      for (int i = 0; i < (1 << s); i++) begin
         sh = wd >> (8 * ((a + i) % 4));
         mem_b[a + i] = sh[7:0];
      end
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] a);
      int w;
      w = int'(a) & ~3;
      return {mem_b[w+3], mem_b[w+2], mem_b[w+1], mem_b[w]};
   endfunction

   task automatic push(input logic [31:0] rd, input logic rdy, input logic resp, input int off);
      exp_t e;
      e.rd = rd; e.rdy = rdy; e.resp = resp; e.due = cyc + off; e.tag = tag_n;
      q.push_back(e);
   endtask

   // ---------------- stimulus ----------------
   task automatic beat(input logic sel, input logic [1:0] tr, input logic wr,
                       input logic [2:0] sz, input logic [31:0] ad, input logic [31:0] wd);
      logic acc;
      logic err;
      tag_n++;
      hsel = sel; htrans = tr; hwrite = wr; hsize = sz; haddr = ad;
      hburst = 3'($urandom); hprot = 4'($urandom);
      hwdata = pend_wdata;
      pend_wdata = $urandom;
      acc = sel && (tr[1] == 1'b1);
      err = acc && model_err(ad, sz);
      if (!acc) begin
         push(32'd0, 1'b1, 1'b0, 1);
      end else if (err) begin
         push(32'd0, 1'b0, 1'b1, 1);
         push(32'd0, 1'b1, 1'b1, 2);
      end else if (wr) begin
         model_write(ad, sz, wd);
         pend_wdata = wd;
         push(32'd0, 1'b1, 1'b0, 1);
      end else begin
         push(model_read(ad), 1'b1, 1'b0, 1);
      end
      @(posedge hclk); #1;
      if (err) begin
         // ERR1: whatever the master presents here must be ignored
         hsel = 1'b1; hwrite = 1'b1; hsize = 3'd2;
         htrans = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd2;
         haddr = $urandom_range(0, 255) * 4;
         hwdata = $urandom;
         @(posedge hclk); #1;
      end
   endtask

   task automatic do_reset(input int n);
      tag_n++;
      hreset = 1'b1;
      hsel = 1'b1; htrans = 2'd2; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h40;
      hburst = 3'd0; hprot = 4'd0;
      hwdata = pend_wdata;
      pend_wdata = $urandom;
      for (int i = 0; i < 1024; i++) mem_b[i] = 8'h00;
      repeat (n) @(posedge hclk);
      #1;
      hreset = 1'b0; hsel = 1'b0; htrans = 2'd0;
      push(32'd0, 1'b1, 1'b0, 0);
   endtask

   initial begin
      logic [31:0] a;
      logic [2:0]  sz;
      do_reset(2);
      repeat (3) beat(1'b0, 2'd0, 1'b0, 3'd2, 32'h0, 32'h0);
      beat(1'b1, 2'd2, 1'b0, 3'd2, 32'h10, 32'h0);
      // word write then immediate read-back
      beat(1'b1, 2'd2, 1'b1, 3'd2, 32'h20, 32'hDEADBEEF);
      beat(1'b1, 2'd2, 1'b0, 3'd2, 32'h20, 32'h0);
      // byte and halfword merges, other lanes carry noise
      beat(1'b1, 2'd2, 1'b1, 3'd0, 32'h21, ($urandom & 32'hFFFF00FF) | 32'h0000AA00);
      beat(1'b1, 2'd2, 1'b1, 3'd1, 32'h22, ($urandom & 32'h0000FFFF) | 32'h12340000);
      beat(1'b1, 2'd2, 1'b0, 3'd2, 32'h20, 32'h0);
      // INCR4 write and read, then BUSY inside a burst
      for (int i = 0; i < 4; i++)
         beat(1'b1, (i == 0) ? 2'd2 : 2'd3, 1'b1, 3'd2, 32'h40 + 4 * i, i + 1);
      for (int i = 0; i < 4; i++)
         beat(1'b1, (i == 0) ? 2'd2 : 2'd3, 1'b0, 3'd2, 32'h40 + 4 * i, 32'h0);
      beat(1'b1, 2'd2, 1'b1, 3'd2, 32'h50, 32'h5555AAAA);
      beat(1'b1, 2'd1, 1'b1, 3'd2, 32'h54, 32'hFFFFFFFF);
      beat(1'b1, 2'd3, 1'b0, 3'd2, 32'h50, 32'h0);
      beat(1'b1, 2'd2, 1'b0, 3'd2, 32'h54, 32'h0);
      // misaligned and out-of-range writes; index 0 must stay clean
      beat(1'b1, 2'd2, 1'b1, 3'd2, 32'h402, 32'hCAFEF00D);
      beat(1'b1, 2'd2, 1'b1, 3'd2, 32'h400, 32'hCAFEF00D);
      beat(1'b1, 2'd2, 1'b0, 3'd2, 32'h20, 32'h0);
      beat(1'b1, 2'd2, 1'b0, 3'd2, 32'h0, 32'h0);
      beat(1'b1, 2'd2, 1'b0, 3'd3, 32'h20, 32'h0);
      beat(1'b0, 2'd2, 1'b1, 3'd2, 32'h24, 32'h0BADBAD0);
      beat(1'b1, 2'd2, 1'b0, 3'd2, 32'h24, 32'h0);
      // reset mid-burst
      beat(1'b1, 2'd2, 1'b1, 3'd2, 32'h48, 32'h77);
      beat(1'b1, 2'd3, 1'b1, 3'd2, 32'h4C, 32'h88);
      do_reset(1);
      beat(1'b1, 2'd2, 1'b0, 3'd2, 32'h40, 32'h0);
      beat(1'b1, 2'd2, 1'b0, 3'd2, 32'h20, 32'h0);
      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 149) == 0) begin
            do_reset(1);
         end else begin
            case ($urandom_range(0, 9))
               0:       a = $urandom_range(1024, 1279);
               1:       a = $urandom;
               default: a = $urandom_range(0, 127);
            endcase
            sz = ($urandom_range(0, 9) == 9) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            if (sz <= 3'd2 && $urandom_range(0, 4) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            beat($urandom_range(0, 7) != 0, 2'($urandom), 1'($urandom), sz, a, $urandom);
         end
      end
      repeat (3) beat(1'b0, 2'd0, 1'b0, 3'd2, 32'h0, 32'h0);
      done = 1'b1;
   end

   // ---------------- monitor ----------------
   always @(negedge hclk) begin
      if (q.size() > 0 && q[0].due <= cyc) begin
         n_cmp <= n_cmp + 1;
         if (q[0].due != cyc || hrdata !== q[0].rd || hreadyout !== q[0].rdy || hresp !== q[0].resp) begin
            n_bad <= n_bad + 1;
            $display("FAIL resp beat%0d cyc%0d: got hrdata=%h hreadyout=%b hresp=%b, expected hrdata=%h hreadyout=%b hresp=%b",
                     q[0].tag, cyc, hrdata, hreadyout, hresp, q[0].rd, q[0].rdy, q[0].resp);
         end
         void'(q.pop_front());
      end else if (fin) begin
         $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
         $finish;
      end else if (done) begin
         n_cmp <= n_cmp + 1;
         if (q.size() != 0) begin
            n_bad <= n_bad + 1;
            $display("FAIL leftover: %0d responses outstanding, expected 0", q.size());
         end
         fin <= 1'b1;
      end
   end

   initial begin
      #500000;
      $display("FAIL timeout: bench did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ahb_lite_slave.md
Name: ahb_lite_slave

Overview:
- AHB-lite memory-backed slave with zero wait states on OKAY transfers and a two-cycle ERROR response.
- Sits behind the AHB interconnect and is driven by the AHB master agent (hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata).
- Returns hrdata, hreadyout and a single-bit hresp; hready is the interconnect's combined ready.

Parameters:
- ADDR_WIDTH, 32, address bus width.
- DATA_WIDTH, 32, data bus width; only 32 is supported.
- MEM_DEPTH, 256, number of DATA_WIDTH-bit words; valid byte range is 0 to MEM_DEPTH*4-1.

Ports:
- hclk  input  1  clock; all logic on its rising edge.
- hreset  input  1  synchronous, active-high reset.
- hsel  input  1  slave select.
- haddr  input  ADDR_WIDTH  byte address (address phase).
- htrans  input  2  0=IDLE, 1=BUSY, 2=NONSEQ, 3=SEQ.
- hwrite  input  1  1=write, 0=read.
- hsize  input  3  0=byte, 1=halfword, 2=word; 3 to 7 are illegal.
- hburst  input  3  burst type; ignored.
- hprot  input  4  protection; ignored.
- hready  input  1  bus ready; the address phase is sampled only when high.
- hwdata  input  DATA_WIDTH  write data (data phase).
- hrdata  output  DATA_WIDTH  read data (data phase).
- hreadyout  output  1  slave ready.
- hresp  output  1  0=OKAY, 1=ERROR.

Behaviour:
- Reset (hreset=1 at a clock edge):
  - hreadyout=1, hresp=0, hrdata=0.
  - FSM goes to OKAY; the data-phase valid flag is cleared.
  - All memory words are cleared to 0.
  - Reset asserted mid-transfer aborts it; no memory write occurs.
- Transfer accept:
  - A transfer is accepted when hsel & hready & htrans[1] at the rising edge.
  - On accept, register haddr, hwrite and hsize, and set the data-phase valid flag.
  - IDLE or BUSY, or hsel=0, gives no data phase; the outputs are OKAY with hreadyout=1.
- Error check, evaluated at accept:
  - word index haddr[ADDR_WIDTH-1:2] >= MEM_DEPTH;
  - hsize > 2;
  - halfword with haddr[0]=1;
  - word with haddr[1:0] != 0.
- OKAY data phase (one cycle, zero wait):
  - hreadyout=1, hresp=0.
  - Write: at the end of the data phase, write hwdata byte lanes selected by the registered hsize and addr[1:0] (byte uses lane addr[1:0]; halfword uses lanes addr[1]*2 and addr[1]*2+1; word uses all lanes).
  - Read: hrdata = full memory word at the registered word index, combinational during the data phase. The master extracts the lane.
  - hrdata=0 whenever no read data phase is active.
- ERROR response, FSM states OKAY -> ERR1 -> ERR2 -> OKAY:
  - ERR1: hreadyout=0, hresp=1.
  - ERR2: hreadyout=1, hresp=1.
  - No memory write occurs; hrdata=0.
  - A transfer sampled while in ERR2 (hready=1) is accepted normally.
  - The master dropping to IDLE during ERR1 has no effect on the ERR2 cycle.
- Pipelining:
  - Back-to-back NONSEQ/SEQ beats are accepted every cycle.
  - Read-after-write to the same address in consecutive beats returns the new data, because the write commits at the edge that starts the read data phase.
- Bursts: hburst is ignored; each beat is decoded from its own haddr. INCR, WRAP and SEQ beats need no special handling.
- BUSY inside a burst gives an OKAY zero-wait response with no access.

Decomposition:
- Package ahb_pkg:
  - htrans_t enum (IDLE, BUSY, NONSEQ, SEQ);
  - hsize constants (BYTE, HALF, WORD);
  - HRESP_OKAY/HRESP_ERROR;
  - FSM state enum (OKAY, ERR1, ERR2);
  - default ADDR_WIDTH/DATA_WIDTH.
- One sub-module, ahb_slave_mem:
  - MEM_DEPTH x 32 array with 4-bit byte write-enable and synchronous clear;
  - asynchronous read port.
- The top level holds the address-phase register, error decode, FSM and byte-enable generation.

Test Plan:
- Reset, then idle bus -> hreadyout=1, hresp=0, hrdata=0; a read of 0x10 returns 0x00000000.
- NONSEQ word write 0x0000_0020 = 0xDEADBEEF, then read 0x20 -> hrdata=0xDEADBEEF, hresp=0, no wait states.
- Byte write 0xAA to 0x21, then halfword write 0x1234 to 0x22, then word read 0x20 -> 0x1234AAEF.
- INCR4 write burst 0x40 to 0x4C with data 1,2,3,4 back-to-back, then INCR4 read -> 1,2,3,4; read-after-write in the next cycle returns the new data.
- Word write to 0x0000_0402 (misaligned), and separately to 0x0000_0400 (out of range, word index 256):
  - each -> ERR1 (hreadyout=0, hresp=1), then ERR2 (hreadyout=1, hresp=1);
  - memory is unchanged;
  - the next read of 0x20 returns OKAY with 0x1234AAEF.
- Assert hreset mid-burst -> the next-cycle outputs are at reset values and a read of 0x40 returns 0.
